mc_ctrl: RTL

//  Multi-cycle MIPS control FSM. Sequences one shared ALU, one unified instruction/data memory port
//  and the register file over FETCH/DECODE/EXECUTE/MEM/WB steps.

---
 rtl/mc_ctrl_pkg.sv | 90 +++++++++
 rtl/mc_ctrl_dec.sv | 61 ++++++
 rtl/mc_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS controller.
//   state_t   : controller FSM states (also exported on state_o)
//   cls_t     : instruction class produced by mc_ctrl_dec
//   ALU_*     : ALUOp encodings
//   NPC_*     : NPCOp encodings
//   GPRSel_*  : register-file write address select
//   WDSel_*   : register-file write data select
//   OP_*/F_*  : supported opcode / function-field values
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_HALT    = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        CLS_RALU = 4'd0,
        CLS_IALU = 4'd1,
        CLS_LW   = 4'd2,
        CLS_SW   = 4'd3,
        CLS_BEQ  = 4'd4,
        CLS_BNE  = 4'd5,
        CLS_J    = 4'd6,
        CLS_JAL  = 4'd7,
        CLS_JR   = 4'd8,
        CLS_JALR = 4'd9,
        CLS_ILL  = 4'd10
    } cls_t;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [1:0] GPRSel_RD  = 2'b00;
    localparam logic [1:0] GPRSel_RT  = 2'b01;
    localparam logic [1:0] GPRSel_31  = 2'b10;

    localparam logic [1:0] WDSel_ALU  = 2'b00;
    localparam logic [1:0] WDSel_MEM  = 2'b01;
    localparam logic [1:0] WDSel_PC   = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational instruction decoder for mc_ctrl.
// Ports:
//   op_i        [5:0] IR opcode field
//   funct_i     [5:0] IR function field
//   cls_o       instruction class (CLS_ILL for anything unsupported)
//   alu_op_o    [3:0] ALU operation for the execute step
//   ext_op_o    1 = sign-extend immediate
//   alu_src_a_o 1 = shamt on ALU port A (shift instructions)
//   illegal_o   unsupported Op/Funct combination
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output cls_t       cls_o,
    output logic [3:0] alu_op_o,
    output logic       ext_op_o,
    output logic       alu_src_a_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o       = CLS_ILL;
        alu_op_o    = ALU_NOP;
        ext_op_o    = 1'b0;
        alu_src_a_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                cls_o = CLS_RALU;
                case (funct_i)
                    F_ADD, F_ADDU: alu_op_o = ALU_ADD;
                    F_SUB, F_SUBU: alu_op_o = ALU_SUB;
                    F_AND:         alu_op_o = ALU_AND;
                    F_OR:          alu_op_o = ALU_OR;
                    F_NOR:         alu_op_o = ALU_NOR;
                    F_SLT:         alu_op_o = ALU_SLT;
                    F_SLTU:        alu_op_o = ALU_SLTU;
                    F_SLL: begin alu_op_o = ALU_SLL; alu_src_a_o = 1'b1; end
                    F_SRL: begin alu_op_o = ALU_SRL; alu_src_a_o = 1'b1; end
                    F_SRA: begin alu_op_o = ALU_SRA; alu_src_a_o = 1'b1; end
                    F_JR:          cls_o = CLS_JR;
                    F_JALR:        cls_o = CLS_JALR;
                    default:       cls_o = CLS_ILL;
                endcase
            end
            OP_ADDI: begin cls_o = CLS_IALU; alu_op_o = ALU_ADD; ext_op_o = 1'b1; end
            // ori zero-extends its immediate
            OP_ORI:  begin cls_o = CLS_IALU; alu_op_o = ALU_OR;  ext_op_o = 1'b0; end
            OP_LW:   begin cls_o = CLS_LW;   alu_op_o = ALU_ADD; ext_op_o = 1'b1; end
            OP_SW:   begin cls_o = CLS_SW;   alu_op_o = ALU_ADD; ext_op_o = 1'b1; end
            OP_BEQ:  begin cls_o = CLS_BEQ;  alu_op_o = ALU_SUB; end
            OP_BNE:  begin cls_o = CLS_BNE;  alu_op_o = ALU_SUB; end
            OP_J:    cls_o = CLS_J;
            OP_JAL:  cls_o = CLS_JAL;
            default: cls_o = CLS_ILL;
        endcase
    end

    assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM. Sequences a shared ALU, a unified
// instruction/data memory port and the register file through
// FETCH/DECODE/EXECUTE/MEM/WB steps.
// Optional feature macro: MC_CTRL_PERF_EN adds cyc_cnt/instr_cnt counters.
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   Op, Funct            IR[31:26] / IR[5:0]
//   Zero                 ALU zero flag, used in BRANCH
//   mem_ready            memory access completes this cycle
//   mem_req, IorD        memory request / address select (0 PC, 1 ALUOut)
//   IRWrite, PCWrite     IR and PC load enables
//   MemWrite, RegWrite   store / register-file write enables
//   EXTOp, ALUOp         immediate extension, ALU operation
//   NPCOp                next-PC select
//   ALUSrcA, ALUSrcB     ALU operand selects
//   GPRSel, WDSel        register write address / data selects
//   mem_err, illegal     sticky error flags
//   state_o              current FSM state (debug)
//   cyc_cnt, instr_cnt   performance counters (MC_CTRL_PERF_EN only)
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       mem_err,
    output logic       illegal,
    output logic [3:0] state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    // Wait counter only needs to reach MEM_WAIT_MAX-1
    localparam int unsigned TW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
    localparam logic [TW-1:0] TO_LAST = TW'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          illegal_q, illegal_d;
    // run_q is low from reset until the first clock after release: the
    // controller sits in FETCH with every output at 0 for that cycle, and
    // asserting rstn clears it asynchronously, dropping mem_req at once.
    logic          run_q;

    cls_t          cls;
    logic [3:0]    dec_alu_op;
    logic          dec_ext_op;
    logic          dec_src_a;
    logic          dec_illegal;

    mc_ctrl_dec u_dec (
        .op_i        (Op),
        .funct_i     (Funct),
        .cls_o       (cls),
        .alu_op_o    (dec_alu_op),
        .ext_op_o    (dec_ext_op),
        .alu_src_a_o (dec_src_a),
        .illegal_o   (dec_illegal)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            illegal_q <= illegal_d;
            run_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        mem_err_d = mem_err_q;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        EXTOp     = 1'b0;
        ALUOp     = ALU_NOP;
        NPCOp     = NPC_PLUS4;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        GPRSel    = GPRSel_RD;
        WDSel     = WDSel_ALU;

        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        NPCOp   = NPC_PLUS4;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (cls)
                        CLS_RALU:                    state_d = S_EXE_R;
                        CLS_IALU:                    state_d = S_EXE_I;
                        CLS_LW, CLS_SW:              state_d = S_MEM_ADR;
                        CLS_BEQ, CLS_BNE:            state_d = S_BRANCH;
                        CLS_J, CLS_JAL,
                        CLS_JR, CLS_JALR:            state_d = S_JUMP;
                        default: begin
                            state_d   = S_HALT;
                            illegal_d = illegal_q | dec_illegal | 1'b1;
                        end
                    endcase
                end
                S_EXE_R, S_EXE_I: begin
                    ALUOp   = dec_alu_op;
                    ALUSrcA = dec_src_a;
                    ALUSrcB = (state_q == S_EXE_I);
                    EXTOp   = dec_ext_op;
                    state_d = S_WB_ALU;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    WDSel    = WDSel_ALU;
                    GPRSel   = (cls == CLS_IALU) ? GPRSel_RT : GPRSel_RD;
                    state_d  = S_FETCH;
                end
                S_MEM_ADR: begin
                    ALUOp   = ALU_ADD;
                    ALUSrcB = 1'b1;
                    EXTOp   = 1'b1;
                    state_d = (cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) state_d = S_WB_MEM;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    WDSel    = WDSel_MEM;
                    GPRSel   = GPRSel_RT;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    ALUOp = ALU_SUB;
                    if (((cls == CLS_BEQ) && Zero) || ((cls == CLS_BNE) && !Zero)) begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_BRANCH;
                    end
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    NPCOp   = ((cls == CLS_JR) || (cls == CLS_JALR)) ? NPC_JR : NPC_JUMP;
                    if ((cls == CLS_JAL) || (cls == CLS_JALR)) begin
                        RegWrite = 1'b1;
                        WDSel    = WDSel_PC;
                        GPRSel   = GPRSel_31;
                    end
                    state_d = S_FETCH;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_HALT;
            endcase

            // Handshake timeout: count stalled request cycles; the
            // MEM_WAIT_MAX-th consecutive stall aborts into HALT.
            if (mem_req && !mem_ready) begin
                if ((MEM_WAIT_MAX != 0) && (cnt_q == TO_LAST)) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
        end
    end

    assign mem_err = mem_err_q;
    assign illegal = illegal_q;
    assign state_o = state_q;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] instr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q   <= '0;
            instr_q <= '0;
        end else begin
            if (run_q && (state_q != S_HALT)) cyc_q <= cyc_q + CNT_W'(1);
            // Any transition into FETCH marks a completed instruction
            if (run_q && (state_d == S_FETCH) && (state_q != S_FETCH))
                instr_q <= instr_q + CNT_W'(1);
        end
    end

    assign cyc_cnt   = cyc_q;
    assign instr_cnt = instr_q;
`endif

endmodule
